// File: rtl/types_pkg.sv
// Shared flit types for the router datapath and its link serializer/deserializer.
package types;

    typedef logic [31:0] flit_t;

    localparam int LINK_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        CHECK
    } ser_state_t;

endpackage

// File: rtl/flit_serializer.sv
// Splits each flit into LINK_WIDTH-bit beats (LSB-first) and appends an XOR
// checksum beat marked with link_last.
module flit_serializer
    import types::*;
#(
    parameter int FLIT_WIDTH = $bits(flit_t),
    parameter int LINK_WIDTH = LINK_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] flit,
    input  logic                  flit_valid,
    output logic                  flit_ready,
    output logic [LINK_WIDTH-1:0] link_data,
    output logic                  link_valid,
    output logic                  link_last,
    input  logic                  link_ready
);

    localparam int SAFE_LW   = (LINK_WIDTH < 1) ? 1 : LINK_WIDTH;
    localparam int NUM_BEATS = (FLIT_WIDTH + SAFE_LW - 1) / SAFE_LW;
    localparam int PAD_WIDTH = NUM_BEATS * SAFE_LW;
    localparam int CNT_WIDTH = $clog2(NUM_BEATS + 1);
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(NUM_BEATS - 1);

    if (LINK_WIDTH > FLIT_WIDTH || LINK_WIDTH < 1) begin : g_bad_width
        $error("flit_serializer: LINK_WIDTH must be in 1..FLIT_WIDTH");
    end

    ser_state_t             state_reg, state_next;
    logic                   armed_reg;
    logic [PAD_WIDTH-1:0]   shift_reg;
    logic [CNT_WIDTH-1:0]   cnt_reg;
    logic [LINK_WIDTH-1:0]  csum_reg;
    logic                   accept;
    logic                   beat_xfer;

    // armed_reg keeps flit_ready low until the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            armed_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            armed_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
            csum_reg  <= '0;
        end else if (accept) begin
            shift_reg <= PAD_WIDTH'(flit);
            cnt_reg   <= '0;
            csum_reg  <= '0;
        end else if (beat_xfer) begin
            shift_reg <= shift_reg >> LINK_WIDTH;
            csum_reg  <= csum_reg ^ shift_reg[LINK_WIDTH-1:0];
            cnt_reg   <= cnt_reg + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        state_next = state_reg;
        flit_ready = 1'b0;
        link_valid = 1'b0;
        link_last  = 1'b0;
        link_data  = '0;
        case (state_reg)
            IDLE: begin
                flit_ready = armed_reg;
                if (flit_valid && armed_reg) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                link_valid = 1'b1;
                link_data  = shift_reg[LINK_WIDTH-1:0];
                if (link_ready && cnt_reg == LAST_BEAT) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                link_valid = 1'b1;
                link_last  = 1'b1;
                link_data  = csum_reg;
                if (link_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept    = flit_ready && flit_valid;
    assign beat_xfer = (state_reg == SEND) && link_ready;

endmodule
